// File: rtl/risc_boot_loader.sv
// Framed byte-stream loader for the risc_cpu 32x8 memory: SYNC, LEN, data, CSUM.
// Holds the CPU in reset until a checksum-verified image is resident.
module risc_boot_loader #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    TIMEOUT    = 1024,
  parameter logic [DATA_WIDTH-1:0] SYNC       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  err
);

  localparam int LW     = ADDR_WIDTH + 1;
  localparam int MAXLEN = 2**ADDR_WIDTH;
  localparam int TW     = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [TW-1:0]         r_to;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_cpu_rst;
  logic                  r_load_done;
  logic                  r_err;

  logic                  w_acc;
  logic                  w_active;
  logic                  w_len_bad;
  logic                  w_timeout;
  logic [LW-1:0]         w_cnt_inc;
  logic [TW-1:0]         w_to_inc;
  logic                  w_wr_nxt;
  logic                  w_cpu_rst_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;

  // The loader never back-pressures, so every valid byte is a transfer.
  assign w_acc     = rx_valid;
  assign w_active  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_len_bad = (rx_data == '0) ||
                     ({1'b0, rx_data} > (DATA_WIDTH+1)'(MAXLEN));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_to_inc  = r_to + 1'b1;
  assign w_timeout = w_active && !w_acc && (w_to_inc == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR:
        if (w_acc && rx_data == SYNC) w_state_nxt = S_LEN;
      S_LEN:
        if (w_acc) w_state_nxt = w_len_bad ? S_ERR : S_DATA;
      S_DATA:
        if (w_acc && w_cnt_inc == r_len) w_state_nxt = S_CSUM;
      S_CSUM:
        if (w_acc) w_state_nxt = (rx_data == r_sum) ? S_DONE : S_ERR;
      default:
        w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_ERR;
  end

  // Output logic, decoded from the next state so the registered flags track it
  always_comb begin
    w_wr_nxt      = (r_state == S_DATA) && w_acc;
    w_cpu_rst_nxt = (w_state_nxt != S_DONE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_err_nxt     = (w_state_nxt == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_to        <= '0;
    end else begin
      r_mem_wr    <= w_wr_nxt;
      r_cpu_rst   <= w_cpu_rst_nxt;
      r_load_done <= w_done_nxt;
      r_err       <= w_err_nxt;
      if (w_wr_nxt) begin
        r_mem_addr <= r_cnt[ADDR_WIDTH-1:0];
        r_mem_data <= rx_data;
        r_cnt      <= w_cnt_inc;
        r_sum      <= r_sum + rx_data;
      end
      if (r_state == S_LEN && w_acc && !w_len_bad) begin
        r_len <= LW'(rx_data);
        r_cnt <= '0;
        r_sum <= '0;
      end
      // Idle counter runs only while a frame is in flight
      if (!w_active || w_acc || w_timeout) r_to <= '0;
      else                                 r_to <= w_to_inc;
    end
  end

  assign rx_ready  = 1'b1;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign cpu_rst   = r_cpu_rst;
  assign load_done = r_load_done;
  assign err       = r_err;

endmodule

// File: tb/tb_risc_boot_loader.sv
// Bench for risc_boot_loader: directed frames plus random frames, checked every
// cycle against a frame-level reference model.
module tb_risc_boot_loader;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, mem_wr, cpu_rst, load_done, err;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;

  always #5 clk = ~clk;

  risc_boot_loader #(
    .ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT(TO), .SYNC(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_rst(cpu_rst), .load_done(load_done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame phase plus byte bookkeeping
  localparam int P_IDLE = 0, P_LEN = 1, P_DATA = 2, P_CSUM = 3, P_DONE = 4, P_ERR = 5;
  int         ph;
  int         m_len, m_cnt, m_sum, m_idle;
  logic       e_wr;
  logic [4:0] e_addr;
  logic [7:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_len = 0; m_cnt = 0; m_sum = 0; m_idle = 0;
    e_wr = 1'b0; e_addr = '0; e_data = '0;
  endtask

  task automatic model(input bit v, input logic [7:0] d);
    e_wr = 1'b0;
    if (!v && (ph == P_LEN || ph == P_DATA || ph == P_CSUM)) begin
      m_idle++;
      if (m_idle == TO - 1) begin
        ph = P_ERR;
        m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
    if (v) begin
      case (ph)
        P_IDLE, P_DONE, P_ERR: if (d == 8'hA5) ph = P_LEN;
        P_LEN: begin
          if (d == 0 || int'(d) > 32) ph = P_ERR;
          else begin
            m_len = int'(d); m_cnt = 0; m_sum = 0; ph = P_DATA;
          end
        end
        P_DATA: begin
          e_wr = 1'b1; e_addr = 5'(m_cnt); e_data = d;
          m_sum = (m_sum + int'(d)) % 256;
          m_cnt++;
          if (m_cnt == m_len) ph = P_CSUM;
        end
        P_CSUM: ph = (int'(d) == m_sum) ? P_DONE : P_ERR;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic check_outs();
    chk("rx_ready", rx_ready, 1);
    chk("cpu_rst", cpu_rst, (ph != P_DONE));
    chk("load_done", load_done, (ph == P_DONE));
    chk("err", err, (ph == P_ERR));
    chk("mem_wr", mem_wr, e_wr);
    if (e_wr) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_data", mem_data, e_data);
    end
  endtask

  // One clock: drive at the falling edge, check 1ns after the rising edge
  task automatic step(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model(v, d);
    #1;
    check_outs();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic b(input logic [7:0] d);
    step(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 255));
  endtask

  // Called at a falling edge; asserts reset between clock edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_frame(input int kind);
    int          len;
    logic [7:0]  d;
    int          sum;
    len = $urandom_range(1, 32);
    sum = 0;
    b(8'hA5);
    if (kind == 3) begin
      if ($urandom_range(0, 1) == 0) b(8'h00);
      else b(8'($urandom_range(33, 255)));
      return;
    end
    b(8'(len));
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (kind == 2 && i == len / 2) idle(TO);
      d = 8'($urandom_range(0, 255));
      sum = (sum + int'(d)) % 256;
      b(d);
    end
    if (kind == 1) b(8'((sum + $urandom_range(1, 255)) % 256));
    else b(8'(sum));
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic frame
    b(8'hA5); b(8'h03); b(8'h11); b(8'h22); b(8'h33); b(8'h66);
    chk("basic_cpu_rst", cpu_rst, 0);
    chk("basic_done", load_done, 1);
    idle(2);

    // Bad checksum then recovery
    b(8'hA5); b(8'h03); b(8'h11); b(8'h22); b(8'h33); b(8'h67);
    chk("badcs_err", err, 1);
    chk("badcs_cpu_rst", cpu_rst, 1);
    b(8'hA5); b(8'h01); b(8'h07); b(8'h07);
    chk("recover_done", load_done, 1);
    chk("recover_err", err, 0);

    // Full 32-byte image
    b(8'hA5); b(8'h20);
    for (int i = 0; i < 32; i++) b(8'(i));
    b(8'hF0);
    chk("full_done", load_done, 1);

    // Oversized and zero length
    b(8'hA5); b(8'h21);
    chk("len33_err", err, 1);
    b(8'h00);
    b(8'hA5); b(8'h00);
    chk("len0_err", err, 1);
    b(8'hA5); b(8'h01); b(8'h09); b(8'h09);

    // Junk in DONE, then reload with SYNC values as payload
    b(8'h5A);
    chk("junk_cpu_rst", cpu_rst, 0);
    b(8'hA5);
    chk("reload_cpu_rst", cpu_rst, 1);
    b(8'h02); b(8'hA5); b(8'h01); b(8'hA6);
    chk("payload_sync_done", load_done, 1);

    // Timeout mid-frame
    b(8'hA5); b(8'h02); b(8'h10);
    idle(TO - 2);
    chk("to_not_yet", err, 0);
    idle(1);
    chk("to_err", err, 1);
    idle(2);

    // Asynchronous reset mid-frame, following byte discarded
    b(8'hA5); b(8'h04); b(8'h01);
    do_reset();
    b(8'h01);
    chk("post_rst_wr", mem_wr, 0);

    // Random frames
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) begin
        for (int j = 0; j < 3; j++) step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      end else if (k == 9 && n % 4 == 0) begin
        b(8'hA5); b(8'h05); b(8'($urandom_range(0, 255)));
        do_reset();
      end else begin
        rand_frame(k <= 3 ? k : 4);
      end
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
